io_input_conditioner: RTL and testbench



---
 rtl/io_input_conditioner_if.sv | 40 ++++
 rtl/io_input_conditioner.sv | 116 +++++++++++
 tb/tb_io_input_conditioner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/io_input_conditioner_if.sv
// Board-input conditioner bus: raw switch/button inputs in,
// debounced levels and the packed IO status word out.
interface io_input_conditioner_if;
  logic        sw0_raw;
  logic        sw1_raw;
  logic        pb0_raw;
  logic        pb_ack;
  logic        io_sw0;
  logic        io_sw1;
  logic        pb_level;
  logic        pb_event;
  logic [3:0]  press_count;
  logic [15:0] io_word;

  modport slave (
    input  sw0_raw,
    input  sw1_raw,
    input  pb0_raw,
    input  pb_ack,
    output io_sw0,
    output io_sw1,
    output pb_level,
    output pb_event,
    output press_count,
    output io_word
  );

  modport master (
    output sw0_raw,
    output sw1_raw,
    output pb0_raw,
    output pb_ack,
    input  io_sw0,
    input  io_sw1,
    input  pb_level,
    input  pb_event,
    input  press_count,
    input  io_word
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces SW0/SW1/PB0, tracks PB0 presses,
// and packs the status word read by the IO mux at 0xfff0.
module io_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);
  localparam logic [CNT_W-1:0] CMAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // any agreeing cycle restarts qualification
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
endmodule

module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  io_input_conditioner_if.slave         bus
);
  logic       w_sw0;
  logic       w_sw1;
  logic       w_pb;
  logic       w_rise;
  logic       r_pb_prev;
  logic       r_event;
  logic [3:0] r_press_cnt;

  io_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw0 (
    .clock    (clock),
    .reset    (reset),
    .i_raw    (bus.sw0_raw),
    .o_stable (w_sw0)
  );

  io_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw1 (
    .clock    (clock),
    .reset    (reset),
    .i_raw    (bus.sw1_raw),
    .o_stable (w_sw1)
  );

  io_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_pb0 (
    .clock    (clock),
    .reset    (reset),
    .i_raw    (bus.pb0_raw),
    .o_stable (w_pb)
  );

  assign w_rise = w_pb & ~r_pb_prev;

  // a press on the ack cycle must not be lost: set wins
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pb_prev   <= 1'b0;
      r_event     <= 1'b0;
      r_press_cnt <= 4'd0;
    end else begin
      r_pb_prev <= w_pb;
      if (w_rise) begin
        r_event     <= 1'b1;
        r_press_cnt <= r_press_cnt + 4'd1;
      end else if (bus.pb_ack) begin
        r_event <= 1'b0;
      end
    end
  end

  assign bus.io_sw0      = w_sw0;
  assign bus.io_sw1      = w_sw1;
  assign bus.pb_level    = w_pb;
  assign bus.pb_event    = r_event;
  assign bus.press_count = r_press_cnt;
  assign bus.io_word     = {r_press_cnt, 9'd0,
                            w_sw1, w_sw0, r_event};
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed plus randomized bench for io_input_conditioner,
// checked against a sample-history reference model.
module tb_io_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  io_input_conditioner_if bus ();

  io_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // raw samples per channel (0=sw0,1=sw1,2=pb0), oldest first
  bit hist[3][$];
  bit mst[3];
  bit mprev;
  bit mev;
  int mcnt;

  function automatic bit s2_at(int ch, int j);
    int idx;
    idx = hist[ch].size() - 2 - j;
    if (idx < 0) return 1'b0;
    return hist[ch][idx];
  endfunction

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit raw[3];
    bit nst[3];
    bit rise;
    bit all;
    logic [23:0] e;
    logic [23:0] o;
    @(posedge clk);
    raw[0] = bus.sw0_raw;
    raw[1] = bus.sw1_raw;
    raw[2] = bus.pb0_raw;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        hist[c].delete();
        mst[c] = 1'b0;
      end
      mprev = 1'b0;
      mev   = 1'b0;
      mcnt  = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        all = 1'b1;
        for (int j = 0; j < D; j++)
          if (s2_at(c, j) == mst[c]) all = 1'b0;
        nst[c] = all ? ~mst[c] : mst[c];
      end
      rise = mst[2] & ~mprev;
      if (rise) begin
        mev  = 1'b1;
        mcnt = (mcnt + 1) % 16;
      end else if (bus.pb_ack) begin
        mev = 1'b0;
      end
      mprev = mst[2];
      for (int c = 0; c < 3; c++) begin
        hist[c].push_back(raw[c]);
        if (hist[c].size() > 64)
          void'(hist[c].pop_front());
        mst[c] = nst[c];
      end
    end
    #1;
    e = {mst[2], mst[1], mst[0], mev,
         4'(mcnt),
         4'(mcnt), 9'd0, mst[1], mst[0], mev};
    o = {bus.pb_level, bus.io_sw1, bus.io_sw0,
         bus.pb_event, bus.press_count, bus.io_word};
    check("model", 32'(o), 32'(e));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    bus.pb0_raw = 1'b1;
    ticks(8);
    bus.pb0_raw = 1'b0;
    ticks(8);
  endtask

  initial begin
    rst         = 1'b1;
    bus.sw0_raw = 1'b0;
    bus.sw1_raw = 1'b0;
    bus.pb0_raw = 1'b0;
    bus.pb_ack  = 1'b0;
    ticks(3);
    check("reset_word", 32'(bus.io_word), 32'h0);
    rst = 1'b0;
    tick();
    check("post_reset", 32'(bus.io_word), 32'h0);
    ticks(4);

    // SW0 clean rise: accepted on the 6th sampling edge
    bus.sw0_raw = 1'b1;
    ticks(5);
    check("sw0_early", 32'(bus.io_sw0), 32'h0);
    tick();
    check("sw0_word", 32'(bus.io_word), 32'h0002);

    // SW1 bounce never qualifies, then clean hold
    for (int i = 0; i < 20; i++) begin
      bus.sw1_raw = ~i[0];
      tick();
    end
    check("sw1_bounce", 32'(bus.io_sw1), 32'h0);
    bus.sw1_raw = 1'b1;
    ticks(5);
    check("sw1_early", 32'(bus.io_sw1), 32'h0);
    tick();
    check("sw1_set", 32'(bus.io_sw1), 32'h1);

    bus.sw0_raw = 1'b0;
    bus.sw1_raw = 1'b0;
    ticks(8);

    // PB0 press, then acknowledge
    bus.pb0_raw = 1'b1;
    ticks(6);
    check("pb_level", 32'(bus.pb_level), 32'h1);
    check("pb_no_evt", 32'(bus.pb_event), 32'h0);
    tick();
    check("pb_word", 32'(bus.io_word), 32'h1001);
    bus.pb_ack = 1'b1;
    tick();
    bus.pb_ack = 1'b0;
    check("ack_word", 32'(bus.io_word), 32'h1000);
    bus.pb0_raw = 1'b0;
    ticks(8);
    check("release", 32'(bus.io_word), 32'h1000);

    // ack coincident with a rising edge: set wins
    bus.pb0_raw = 1'b1;
    ticks(6);
    bus.pb_ack = 1'b1;
    tick();
    bus.pb_ack = 1'b0;
    check("ack_race", 32'(bus.io_word), 32'h2001);
    bus.pb0_raw = 1'b0;
    ticks(8);

    // 15 more presses: 17 total wraps to 1
    for (int i = 0; i < 15; i++) press();
    check("wrap", 32'(bus.press_count), 32'h1);

    // reset mid-qualification with PB0 held
    bus.pb0_raw = 1'b1;
    ticks(4);
    rst = 1'b1;
    ticks(3);
    check("rst_hold", 32'(bus.io_word), 32'h0);
    check("rst_lvl", 32'(bus.pb_level), 32'h0);
    rst = 1'b0;
    ticks(5);
    check("requal_early", 32'(bus.pb_level), 32'h0);
    tick();
    check("requal_lvl", 32'(bus.pb_level), 32'h1);
    tick();
    check("requal_evt", 32'(bus.io_word), 32'h1001);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0)
        bus.sw0_raw = ~bus.sw0_raw;
      if ($urandom_range(0, 5) == 0)
        bus.sw1_raw = ~bus.sw1_raw;
      if ($urandom_range(0, 4) == 0)
        bus.pb0_raw = ~bus.pb0_raw;
      bus.pb_ack = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    bus.pb_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
